// File: rtl/pop_arbiter.sv
// -----------------------------------------------------------------------------
// pop_arbiter
//   Round-robin arbiter that drains four source FIFOs into one destination
//   FIFO through a three-stage pipeline:
//     GRANT   (cycle N)   : pop strobe to the winning source
//     CAPTURE (cycle N+1) : the source's read data is registered
//     PUSH    (cycle N+2) : push strobe with data_out / src_id
//
// Ports
//   clk              : clock, rising edge
//   reset            : asynchronous active-low reset
//   empty            : per-source empty flags (registered in the FIFOs,
//                      so each lags its pop by one cycle)
//   data_in0..3      : per-source read data, valid the cycle after a pop
//   dest_almost_full : destination has fewer than 3 free slots
//   pop              : one-hot-or-zero pop strobes (registered)
//   push             : destination push strobe (registered)
//   data_out         : word pushed; holds its value while push=0
//   src_id           : source index of data_out
//   busy             : a word is in the GRANT or CAPTURE stage
// -----------------------------------------------------------------------------
module pop_arbiter #(
   parameter int DATA_WIDTH = 12,
   parameter int NUM_SRC    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_SRC-1:0]    empty,
   input  logic [DATA_WIDTH-1:0] data_in0,
   input  logic [DATA_WIDTH-1:0] data_in1,
   input  logic [DATA_WIDTH-1:0] data_in2,
   input  logic [DATA_WIDTH-1:0] data_in3,
   input  logic                  dest_almost_full,
   output logic [NUM_SRC-1:0]    pop,
   output logic                  push,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [1:0]            src_id,
   output logic                  busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_SRC-1:0]    pop_q, pop_d;
   logic [NUM_SRC-1:0]    elig;
   logic [1:0]            last_q, last_d;
   logic                  found;
   logic [1:0]            win;
   logic                  cap_vld_q;
   logic [1:0]            cap_id_q;
   logic [DATA_WIDTH-1:0] cap_data;
   logic                  push_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic [1:0]            src_id_q;

   // A source granted this cycle is excluded from the next grant: its empty
   // flag has not yet reflected the pop, so it might be out of words.
   always_comb begin : arb_search
      logic [1:0] cand;
      elig  = ~empty & ~pop_q & {NUM_SRC{~dest_almost_full}};
      found = 1'b0;
      win   = last_q;
      cand  = last_q;
      // Search starts one past the last grant; k=4 wraps back to last_q.
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!found && elig[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      pop_d   = '0;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
            end
         end
         GRANT: begin
            state_d = found ? GRANT : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (found) begin
         pop_d[win] = 1'b1;
         last_d     = win;
      end
   end

   always_comb begin : capture_mux
      cap_data = data_in0;
      case (cap_id_q)
         2'd0:    cap_data = data_in0;
         2'd1:    cap_data = data_in1;
         2'd2:    cap_data = data_in2;
         default: cap_data = data_in3;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pop_q      <= '0;
         last_q     <= 2'd3;
         cap_vld_q  <= 1'b0;
         cap_id_q   <= 2'd0;
         push_q     <= 1'b0;
         data_out_q <= '0;
         src_id_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         pop_q     <= pop_d;
         last_q    <= last_d;
         // While a grant is live, last_q holds the index of that grant.
         cap_vld_q <= |pop_q;
         cap_id_q  <= last_q;
         push_q    <= cap_vld_q;
         if (cap_vld_q) begin
            data_out_q <= cap_data;
            src_id_q   <= cap_id_q;
         end
      end
   end

   assign pop      = pop_q;
   assign push     = push_q;
   assign data_out = data_out_q;
   assign src_id   = src_id_q;
   assign busy     = (state_q == GRANT) | cap_vld_q;

endmodule

// File: tb/tb_pop_arbiter.sv
module tb_pop_arbiter;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    empty;
   logic [DW-1:0] din [4];
   logic          daf;
   logic [3:0]    pop;
   logic          push;
   logic [DW-1:0] data_out;
   logic [1:0]    src_id;
   logic          busy;

   pop_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .empty            (empty),
      .data_in0         (din[0]),
      .data_in1         (din[1]),
      .data_in2         (din[2]),
      .data_in3         (din[3]),
      .dest_almost_full (daf),
      .pop              (pop),
      .push             (push),
      .data_out         (data_out),
      .src_id           (src_id),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Source FIFO contents seen by the DUT, the reference copy consumed by the
   // model's grants, and the per-source scoreboard consumed by real pushes.
   logic [DW-1:0] src_q [4][$];
   logic [DW-1:0] ref_q [4][$];
   logic [DW-1:0] sb_q  [4][$];

   // Reference model: pointer, current grant, captured word, pushed word.
   logic [3:0]    m_pop;
   int            m_last;
   int            m_pop_id;
   logic [DW-1:0] m_pop_word;
   logic          m_cap_vld;
   int            m_cap_id;
   logic [DW-1:0] m_cap_word;
   logic          m_push;
   int            m_id;
   logic [DW-1:0] m_out;

   logic [7:0]    hist_pop2;
   logic [7:0]    hist_push2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pop      = 4'b0000;
      m_last     = 3;
      m_pop_id   = 0;
      m_pop_word = '0;
      m_cap_vld  = 1'b0;
      m_cap_id   = 0;
      m_cap_word = '0;
      m_push     = 1'b0;
      m_id       = 0;
      m_out      = '0;
   endtask

   task automatic load(input int s, input logic [DW-1:0] w);
      src_q[s].push_back(w);
      ref_q[s].push_back(w);
      sb_q[s].push_back(w);
      empty[s] = 1'b0;
   endtask

   task automatic flush_all();
      for (int s = 0; s < 4; s++) begin
         src_q[s].delete();
         ref_q[s].delete();
         sb_q[s].delete();
      end
      empty = 4'hF;
   endtask

   // One clock: derive the reference grant from the inputs visible before the
   // edge, let the edge happen, update the source FIFOs, then compare.
   task automatic step();
      logic [3:0]    pop_pre;
      int            win;
      logic [DW-1:0] w;
      win = -1;
      if (!daf) begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (win < 0 && !empty[c] && !m_pop[c]) win = c;
         end
      end
      pop_pre = pop;
      @(posedge clk);
      #1;
      cyc++;
      for (int s = 0; s < 4; s++) begin
         if (pop_pre[s] && src_q[s].size() > 0) din[s] = src_q[s].pop_front();
         empty[s] = (src_q[s].size() == 0);
      end
      m_push = m_cap_vld;
      if (m_cap_vld) begin
         m_out = m_cap_word;
         m_id  = m_cap_id;
      end
      m_cap_vld  = (m_pop != 4'b0000);
      m_cap_id   = m_pop_id;
      m_cap_word = m_pop_word;
      m_pop      = 4'b0000;
      if (win >= 0) begin
         m_pop[win] = 1'b1;
         m_last     = win;
         m_pop_id   = win;
         m_pop_word = (ref_q[win].size() > 0) ? ref_q[win].pop_front() : '0;
      end
      chk("pop",      32'(pop),      32'(m_pop));
      chk("push",     32'(push),     32'(m_push));
      chk("data_out", 32'(data_out), 32'(m_out));
      chk("src_id",   32'(src_id),   32'(m_id));
      chk("busy",     32'(busy),     32'((m_pop != 4'b0000) || m_cap_vld));
      chk("onehot0_pop",  32'($onehot0(pop)), 32'(1));
      chk("pop_on_empty", 32'(pop & empty),   32'(0));
      if (push) begin
         chk("sb_avail", 32'(sb_q[src_id].size() != 0), 32'(1));
         if (sb_q[src_id].size() != 0) begin
            w = sb_q[src_id].pop_front();
            chk("sb_order", 32'(data_out), 32'(w));
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      daf   = 1'b0;
      empty = 4'hF;
      for (int s = 0; s < 4; s++) din[s] = '0;
      model_reset();

      // Reset state
      #12;
      chk("rst_pop",      32'(pop),      32'(0));
      chk("rst_push",     32'(push),     32'(0));
      chk("rst_data_out", 32'(data_out), 32'(0));
      chk("rst_src_id",   32'(src_id),   32'(0));
      chk("rst_busy",     32'(busy),     32'(0));
      reset = 1'b1;

      // Single source with three words: one transfer every other cycle
      load(2, 12'hA0A);
      load(2, 12'hB0B);
      load(2, 12'hC0C);
      for (int k = 0; k < 8; k++) begin
         step();
         hist_pop2[k]  = pop[2];
         hist_push2[k] = push && (src_id == 2'd2);
      end
      chk("single_src_pop_cycles",  32'(hist_pop2),  32'(8'b0001_0101));
      chk("single_src_push_cycles", 32'(hist_push2), 32'(8'b0101_0100));

      // All sources busy: one grant per cycle in rotating order
      for (int s = 0; s < 4; s++)
         for (int j = 0; j < 3; j++) load(s, 12'(16 * s + j + 12'h100));
      repeat (18) step();

      // Destination nearly full during continuous traffic
      for (int s = 0; s < 4; s++)
         for (int j = 0; j < 4; j++) load(s, 12'(16 * s + j + 12'h200));
      repeat (4) step();
      daf = 1'b1;
      step();
      chk("daf_nopop0", 32'(pop), 32'(0));
      chk("daf_push0",  32'(push), 32'(1));
      step();
      chk("daf_nopop1", 32'(pop), 32'(0));
      chk("daf_push1",  32'(push), 32'(1));
      step();
      chk("daf_nopop2", 32'(pop), 32'(0));
      chk("daf_push2",  32'(push), 32'(0));
      daf = 1'b0;
      repeat (20) step();

      // Uneven sources: one word on source 1, two on source 3
      load(1, 12'h311);
      load(3, 12'h331);
      load(3, 12'h332);
      repeat (10) step();

      // Reset in the middle of traffic
      for (int s = 0; s < 4; s++)
         for (int j = 0; j < 3; j++) load(s, 12'(16 * s + j + 12'h400));
      repeat (2) step();
      chk("midop_busy", 32'(busy), 32'(1));
      reset = 1'b0;
      #1;
      chk("arst_pop",      32'(pop),      32'(0));
      chk("arst_push",     32'(push),     32'(0));
      chk("arst_data_out", 32'(data_out), 32'(0));
      chk("arst_src_id",   32'(src_id),   32'(0));
      chk("arst_busy",     32'(busy),     32'(0));
      flush_all();
      model_reset();
      repeat (2) step();
      #2 reset = 1'b1;
      for (int s = 0; s < 4; s++) load(s, 12'(12'h500 + s));
      step();
      chk("first_grant_after_reset", 32'(pop), 32'(4'b0001));
      repeat (12) step();

      // Randomized traffic with intermittent back-pressure
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            int s;
            s = $urandom_range(0, 3);
            if (src_q[s].size() < 5) load(s, 12'($urandom_range(0, 4095)));
         end
         if ($urandom_range(0, 7) == 0) daf = ~daf;
         step();
      end
      daf = 1'b0;
      repeat (40) step();
      for (int s = 0; s < 4; s++) chk($sformatf("drained_src%0d", s), 32'(sb_q[s].size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
